relu_argmax_classifier: RTL and testbench

Sequential argmax stage downstream of the final dense layer. Captures the NUM_IN ReLU node outputs (one 16-bit word per class) in a single handshake and scans them one per cycle. Reports the winning class index and its value with a one-cycle valid pulse. Feeds the ECG classification result to the readout/host interface.

---
 rtl/relu_argmax_classifier.sv | 112 +++++++++++
 tb/tb_relu_argmax_classifier.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/relu_argmax_classifier.sv
// Sequential argmax over NUM_IN ReLU node outputs. The block captures one vector,
// scans one word per cycle, and pulses out_valid with the winning index and value.
module relu_argmax_classifier #(
  parameter int NUM_IN = 5,
  parameter int DW     = 16,
  parameter int IDX_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN*DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [DW-1:0]        out_max,
  output logic                 out_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DW-1:0]    r_buf [NUM_IN];
  logic [IDX_W-1:0] r_ptr;
  logic [DW-1:0]    r_best_val;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_out_idx;
  logic [DW-1:0]    r_out_max;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_last;
  logic [DW-1:0]    w_cand;
  logic             w_take;
  logic [DW-1:0]    w_new_val;
  logic [IDX_W-1:0] w_new_idx;

  // Negative words are treated as zero, matching the upstream ReLU.
  function automatic logic [DW-1:0] sanitize(input logic [DW-1:0] word);
    return word[DW-1] ? '0 : word;
  endfunction

  assign in_ready  = (r_state == IDLE) & ~reset;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_ptr == IDX_W'(NUM_IN - 1));
  assign w_cand    = sanitize(r_buf[r_ptr]);
  // Strictly-greater keeps the lowest index on ties.
  assign w_take    = (w_cand > r_best_val);
  assign w_new_val = w_take ? w_cand : r_best_val;
  assign w_new_idx = w_take ? r_ptr : r_best_idx;

  assign out_idx   = r_out_idx;
  assign out_max   = r_out_max;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: assign the default first so no path leaves w_state_next unassigned (avoids a latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SCAN;
      SCAN:    if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the capture buffer is reset too, so an aborted vector leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_IN; k++) r_buf[k] <= '0;
      r_ptr       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_out_idx   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (r_state == SCAN) && w_last;
      r_busy      <= (w_state_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < NUM_IN; k++) r_buf[k] <= in_data[k*DW +: DW];
            r_best_val <= sanitize(in_data[DW-1:0]);
            r_best_idx <= '0;
            r_ptr      <= IDX_W'(1);
          end
        end
        SCAN: begin
          r_best_val <= w_new_val;
          r_best_idx <= w_new_idx;
          r_ptr      <= r_ptr + 1'b1;
          if (w_last) begin
            r_out_idx <= w_new_idx;
            r_out_max <= w_new_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_argmax_classifier.sv
// Directed bench for relu_argmax_classifier: hand-computed vectors, latency,
// throughput, in_data isolation during a scan, and async reset mid-scan.
module tb_relu_argmax_classifier;
  localparam int NUM_IN = 5;
  localparam int DW     = 16;
  localparam int IDX_W  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_IN*DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_W-1:0]     out_idx;
  logic [DW-1:0]        out_max;
  logic                 out_valid;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  relu_argmax_classifier #(.NUM_IN(NUM_IN), .DW(DW), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_idx(out_idx), .out_max(out_max),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_IN*DW-1:0] pack(input logic [DW-1:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  // Accept one vector, measure latency to out_valid, check result and the cycle after.
  task automatic run_vec(input string tag, input logic [NUM_IN*DW-1:0] v,
                         input logic [IDX_W-1:0] exp_idx, input logic [DW-1:0] exp_max);
    int cyc = 0;
    in_data  = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, cyc, NUM_IN - 1);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_idx"}, out_idx, exp_idx);
    check({tag, "_max"}, out_max, exp_max);
    step();
    check({tag, "_valid_fall"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
    check({tag, "_idx_hold"}, out_idx, exp_idx);
  endtask

  initial begin
    int n_pulse, n_acc, acc_edge, pulse_edge[2];
    logic [IDX_W-1:0] pulse_idx[2];
    logic [DW-1:0]    pulse_max[2];
    logic acc;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_idx", out_idx, '0);
    check("rst_max", out_max, '0);
    reset = 1'b0;
    #1;
    check("rel_ready", in_ready, 1'b1);

    // Basic max with explicit cycle-by-cycle checks.
    in_data  = pack(16'h0010, 16'h0200, 16'h0040, 16'h01FF, 16'h0001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_busy_rise", busy, 1'b1);
    check("basic_ready_low", in_ready, 1'b0);
    step(); step(); step();
    check("basic_no_early_valid", out_valid, 1'b0);
    step();
    check("basic_valid", out_valid, 1'b1);
    check("basic_idx", out_idx, 3'd1);
    check("basic_max", out_max, 16'h0200);
    check("basic_busy_done", busy, 1'b1);
    step();
    check("basic_valid_fall", out_valid, 1'b0);
    check("basic_busy_low", busy, 1'b0);
    check("basic_ready_back", in_ready, 1'b1);

    run_vec("tie",   pack(16'h0300, 16'h0100, 16'h0300, 16'h0050, 16'h0020), 3'd0, 16'h0300);
    run_vec("last",  pack(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h7FFF), 3'd4, 16'h7FFF);
    run_vec("san1",  pack(16'h8005, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000), 3'd0, 16'h0000);
    run_vec("san2",  pack(16'h8000, 16'h0003, 16'h9000, 16'h0002, 16'h0001), 3'd1, 16'h0003);

    // Held valid, back-to-back; in_data swaps to vector B right after A is accepted.
    n_pulse  = 0;
    n_acc    = 0;
    acc_edge = -1;
    pulse_edge[0] = -1; pulse_edge[1] = -1;
    pulse_idx[0] = '0;  pulse_idx[1] = '0;
    pulse_max[0] = '0;  pulse_max[1] = '0;
    in_data  = pack(16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009);
    in_valid = 1'b1;
    step();
    in_data = pack(16'h0050, 16'h0100, 16'h0050, 16'h0050, 16'h0050);
    for (int e = 1; e <= 14; e++) begin
      acc = in_ready & in_valid;
      step();
      if (acc) begin
        n_acc++;
        acc_edge = e;
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (n_pulse < 2) begin
          pulse_edge[n_pulse] = e;
          pulse_idx[n_pulse]  = out_idx;
          pulse_max[n_pulse]  = out_max;
        end
        n_pulse++;
      end
    end
    check("b2b_accepts", n_acc, 1);
    check("b2b_accept_edge", acc_edge, NUM_IN + 1);
    check("b2b_pulses", n_pulse, 2);
    check("b2b_pulse0_edge", pulse_edge[0], NUM_IN - 1);
    check("b2b_pulse1_edge", pulse_edge[1], 2 * NUM_IN);
    check("b2b_a_idx", pulse_idx[0], 3'd4);
    check("b2b_a_max", pulse_max[0], 16'h0009);
    check("b2b_b_idx", pulse_idx[1], 3'd1);
    check("b2b_b_max", pulse_max[1], 16'h0100);

    // Async reset two cycles into a scan, asserted between clock edges.
    in_data  = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_idx", out_idx, '0);
    check("arst_max", out_max, '0);
    check("arst_ready", in_ready, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("arst_rel_ready", in_ready, 1'b1);
    n_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) n_pulse++;
    end
    check("arst_no_valid", n_pulse, 0);
    run_vec("fresh", pack(16'h0000, 16'h0000, 16'h0000, 16'h0007, 16'h0000), 3'd3, 16'h0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
